fetch_sequencer: RTL



---
 rtl/fetch_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch front end: owns the fetch PC, keeps one request outstanding
// to instruction memory, buffers returned words toward decode and applies
// branch redirects (discarding stale responses and flushing the buffer).
module fetch_sequencer #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            branch_en_i,
    input  logic [XLEN-1:0] branch_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            if_valid_o,
    input  logic            if_ready_i,
    output logic [31:0]     if_instr_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic            fetch_misalign_o
);

    // state | meaning
    // IDLE  | no request live; issue next cycle if the buffer has room
    // WAIT  | request live, response will be pushed into the buffer
    // DROP  | request live, response belongs to a redirected-away path
    // HALT  | misaligned redirect seen, fetch stopped until reset
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            misalign_q, misalign_d;

    logic [31:0]     buf_instr_q [DEPTH];
    logic [XLEN-1:0] buf_pc_q    [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [31:0]     last_instr_q;
    logic [XLEN-1:0] last_pc_q;

    logic            push;
    logic            pop;
    logic            misaligned_br;
    logic [CW-1:0]   count_after_pop;

    assign pop             = (count_q != '0) && if_ready_i;
    assign count_after_pop = count_q - CW'(pop);
    assign misaligned_br   = branch_en_i && (branch_pc_i[1:0] != 2'b00);
    assign misalign_d      = misalign_q || misaligned_br;

    // Next-state, PC and request address; a redirect always wins over a push.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (branch_en_i) begin
                    pc_d = branch_pc_i;
                end else if (count_after_pop < CW'(DEPTH)) begin
                    state_d = S_WAIT;
                    addr_d  = pc_q;
                end
            end
            S_WAIT: begin
                if (branch_en_i) begin
                    pc_d    = branch_pc_i;
                    state_d = imem_ack_i ? S_IDLE : S_DROP;
                end else if (imem_ack_i) begin
                    push    = 1'b1;
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                if (branch_en_i) begin
                    pc_d = branch_pc_i;
                end
                if (imem_ack_i) begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                if (branch_en_i) begin
                    pc_d = branch_pc_i;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A pending misalignment parks the sequencer once no request is live.
        if (misalign_d && (state_d == S_IDLE)) begin
            state_d = S_HALT;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            misalign_q <= misalign_d;
        end
    end

    // Instruction buffer; a redirect empties it regardless of push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_instr_q[i] <= '0;
                buf_pc_q[i]    <= '0;
            end
        end else if (branch_en_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                buf_instr_q[wr_ptr_q] <= imem_rdata_i;
                buf_pc_q[wr_ptr_q]    <= pc_q;
                wr_ptr_q              <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Remember the last head shown so the outputs hold while the buffer is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_instr_q <= '0;
            last_pc_q    <= '0;
        end else if (count_q != '0) begin
            last_instr_q <= buf_instr_q[rd_ptr_q];
            last_pc_q    <= buf_pc_q[rd_ptr_q];
        end
    end

    assign imem_req_o       = (state_q == S_WAIT) || (state_q == S_DROP);
    assign imem_addr_o      = addr_q;
    assign if_valid_o       = (count_q != '0);
    assign if_instr_o       = if_valid_o ? buf_instr_q[rd_ptr_q] : last_instr_q;
    assign if_pc_o          = if_valid_o ? buf_pc_q[rd_ptr_q] : last_pc_q;
    assign fetch_misalign_o = misalign_q;

endmodule
